frac_divn_dsm: RTL and testbench
================================

# frac_divn_dsm

Fractional-N divider-ratio generator that feeds the `divn` input of the PLL loop. Once per reference cycle it emits an integer divide ratio from a third-order MASH 1-1-1 delta-sigma modulator. The long-run average of that ratio equals `cfg_int + cfg_frac / 2^FRAC_W`. It runs entirely in the `refclk` domain and sits directly upstream of the PLL. Its output is what the PLL uses as its frequency target and feedback-divider modulus.

## Interface
- `FRAC_W`, 16: fractional word width in bits.
- `INT_W`, 8: integer word width in bits.
- `DIVN_MIN`, 4: lower clamp applied to `divn`.
- `DIVN_MAX`, 255: upper clamp applied to `divn`.
- `DIVN_RST`, 40: value of `divn` and of the active integer register after reset.

Ports (clock and reset first):
- `refclk`  in  1  reference clock, the only clock; every flop updates on its rising edge.
- `resetn`  in  1  reset, synchronous and active-low.
- `cfg_valid`  in  1  new configuration offered.
- `cfg_ready`  out  1  block can accept a configuration.
- `cfg_int`  in  INT_W  integer part of the ratio.
- `cfg_frac`  in  FRAC_W  fractional part of the ratio, unsigned.
- `enable`  in  1  run the modulator; when 0, output the integer part only.
- `divn`  out  int (32)  divide ratio for the current reference cycle.
- `sat`  out  1  one-cycle pulse: `divn` was clamped this cycle.

## Operation
- Reset (`resetn` = 0 at an edge) sets:
  - `acc1`, `acc2`, `acc3` = 0, and both carry delay registers = 0;
  - active int = `DIVN_RST`, active frac = 0;
  - `divn` = `DIVN_RST`, `sat` = 0, `cfg_ready` = 0.
- `cfg_ready` rises at the first edge after reset is released.
- Configuration handshake:
  - A configuration is accepted at an edge where `cfg_valid & cfg_ready`. `cfg_int` and `cfg_frac` are latched into shadow registers and `cfg_ready` drops.
  - At the next edge the shadow registers are copied to the active registers and `cfg_ready` returns to 1.
  - Maximum acceptance rate is therefore one configuration every 2 cycles. `cfg_valid` held high is accepted once per ready window.
- Accumulators are never cleared on a configuration change, so the modulator state stays continuous.
- Modulator, per edge while `enable` = 1:
  - `acc1` += active frac, producing carry `c1`;
  - `acc2` += new `acc1`, producing carry `c2`;
  - `acc3` += new `acc2`, producing carry `c3`.
  - All three accumulators are FRAC_W bits and wrap modulo 2^FRAC_W. Each carry is the overflow bit of its add.
- Noise-shaped offset, signed, range −3..+4: `off = c1 + (c2 − c2_d) + (c3 − 2·c3_d + c3_dd)`.
- Registered output: `divn` = clamp(active int + `off`, `DIVN_MIN`, `DIVN_MAX`). `sat` = 1 exactly in the cycles where clamping changed the value.
- `enable` = 0:
  - accumulators and carry delays hold their values;
  - `divn` = clamp(active int); `sat` reflects that clamp only.
- Active frac = 0 with the accumulators at 0 gives `off` ≡ 0.

## Timing
- Configuration accepted at edge N → active registers loaded at N+1 → first `divn` using it is visible after edge N+2.
- Modulator latency: the `off` term computed at an edge appears on `divn` after that same edge (registered output, 1 cycle from the accumulator inputs).
- `divn` changes only at `refclk` rising edges. The PLL samples it on the same edge family and sees exactly one value per reference cycle.
- Reset asserted mid-operation takes effect at the next edge regardless of handshake state. A pending shadow configuration is discarded.
- If `enable` changes in the same cycle the active registers load, the new integer part is used by whichever path `enable` selects at that edge.

## Configuration
- `FRAC_DSM_DITHER_EN` defined:
  - Adds a 15-bit Fibonacci LFSR, polynomial x^15+x^14+1, seed 15'h0001 on reset.
  - The LFSR advances only while `enable` = 1.
  - Its output bit 0 is added as an LSB to the `acc1` input each cycle, which breaks up idle tones.
- `FRAC_DSM_DITHER_EN` not defined: no LFSR; the `acc1` input is exactly the active frac.

## Structure
- Shared package `frac_dsm_pkg`:
  - `FRAC_W_DEFAULT`, `INT_W_DEFAULT`;
  - LFSR polynomial and seed constants;
  - typedef `dsm_off_t` (signed 4-bit).
- Sub-module `mash_stage`: one FRAC_W accumulator with carry-out and hold input, instantiated three times.

## Test plan
- Reset, then `cfg_int`=40, `cfg_frac`=0, `enable`=1 → `divn` = 40 on every cycle, `sat` never asserts.
- `cfg_int`=40, `cfg_frac`=16'h8000, dither off, 256 cycles → every `divn` in 37..44; the sum of the 256 values is within 10368 ± 4.
- `cfg_int`=4, `cfg_frac`=16'h0001, `DIVN_MIN`=4 → `divn` never below 4; `sat` pulses in every cycle where `off` < 0.
- `cfg_valid` held high for 4 cycles starting at edge N → accepted at N and N+2, `cfg_ready` low at N+1 and N+3, new ratio visible after N+2.
- Run at `cfg_frac`=16'h4000, drop `resetn` for 1 cycle mid-run → next `divn` = 40 (`DIVN_RST`), accumulators 0, `cfg_ready` 0 then 1.
- `enable`=0 for 10 cycles mid-run, then `enable`=1 → `divn` = active int while disabled; the modulator sequence resumes from the held accumulator state.

Source files
------------

// File: rtl/frac_dsm_pkg.sv
// Shared types and constants for the fractional-N MASH 1-1-1 ratio generator.
package frac_dsm_pkg;

   localparam int unsigned FRAC_W_DEFAULT = 16;
   localparam int unsigned INT_W_DEFAULT  = 8;

   // Dither LFSR: Fibonacci x^15 + x^14 + 1
   localparam int unsigned         LFSR_W    = 15;
   localparam logic [LFSR_W-1:0]   LFSR_TAPS = 15'h6000;
   localparam logic [LFSR_W-1:0]   LFSR_SEED = 15'h0001;

   // Noise-shaped offset, range -3..+4
   typedef logic signed [3:0] dsm_off_t;

   // Configuration handshake states
   typedef enum logic [1:0] {
      CFG_INIT = 2'd0,
      CFG_IDLE = 2'd1,
      CFG_LOAD = 2'd2
   } cfg_state_t;

   // Combine stage carries: c1 + (c2 - c2_d) + (c3 - 2*c3_d + c3_dd)
   function automatic dsm_off_t mash_off(input logic c1,
                                         input logic c2,
                                         input logic c2_d,
                                         input logic c3,
                                         input logic c3_d,
                                         input logic c3_dd);
      logic [3:0] s;
      s = {3'b000, c1} + {3'b000, c2} - {3'b000, c2_d}
        + {3'b000, c3} - {2'b00, c3_d, 1'b0} + {3'b000, c3_dd};
      return dsm_off_t'(s);
   endfunction

endpackage

// File: rtl/frac_divn_dsm_mash_stage.sv
// One MASH accumulator stage: W-bit wrapping accumulator with carry-out.
// sum_c/carry_c expose the value being written this edge so the next
// stage can chain on the freshly updated accumulator.
module mash_stage #(
   parameter int unsigned W = 16
) (
   input  logic         refclk,
   input  logic         resetn,
   input  logic         hold,
   input  logic [W-1:0] din,
   input  logic         cin,
   output logic [W-1:0] sum_c,
   output logic         carry_c
);

   logic [W-1:0] acc;
   logic [W:0]   full_c;

   // Wide add so the overflow bit becomes the carry
   always_comb begin
      full_c = {1'b0, acc} + {1'b0, din} + (W+1)'(cin);
   end

   assign sum_c   = full_c[W-1:0];
   assign carry_c = full_c[W];

   // Accumulator update, frozen while hold is set
   always_ff @(posedge refclk) begin
      if (!resetn) begin
         acc <= '0;
      end else if (!hold) begin
         acc <= sum_c;
      end
   end

endmodule

// File: rtl/frac_divn_dsm.sv
// Fractional-N divide-ratio generator (MASH 1-1-1 delta-sigma).
// Emits one clamped integer ratio per refclk whose long-run mean is
// cfg_int + cfg_frac / 2^FRAC_W.
// Optional build macro: FRAC_DSM_DITHER_EN adds LFSR LSB dither on stage 1.
module frac_divn_dsm
   import frac_dsm_pkg::*;
#(
   parameter int unsigned FRAC_W   = FRAC_W_DEFAULT,
   parameter int unsigned INT_W    = INT_W_DEFAULT,
   parameter int          DIVN_MIN = 4,
   parameter int          DIVN_MAX = 255,
   parameter int          DIVN_RST = 40
) (
   input  logic                refclk,
   input  logic                resetn,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [INT_W-1:0]    cfg_int,
   input  logic [FRAC_W-1:0]   cfg_frac,
   input  logic                enable,
   output logic signed [31:0]  divn,
   output logic                sat
);

   cfg_state_t          state;
   logic [INT_W-1:0]    sh_int;
   logic [FRAC_W-1:0]   sh_frac;
   logic [INT_W-1:0]    act_int;
   logic [FRAC_W-1:0]   act_frac;

   logic                dith;
   logic [FRAC_W-1:0]   s1_sum_c, s2_sum_c, s3_sum_c;
   logic                c1_c, c2_c, c3_c;
   logic                c2_d, c3_d, c3_dd;
   dsm_off_t            off_c;
   logic signed [31:0]  raw_c;
   logic signed [31:0]  divn_nxt_c;
   logic                sat_nxt_c;

   // Config handshake: accept into shadow, copy to active on the next edge
   always_ff @(posedge refclk) begin
      if (!resetn) begin
         state     <= CFG_INIT;
         cfg_ready <= 1'b0;
         sh_int    <= '0;
         sh_frac   <= '0;
         act_int   <= INT_W'(DIVN_RST);
         act_frac  <= '0;
      end else begin
         case (state)
            CFG_INIT: begin
               state     <= CFG_IDLE;
               cfg_ready <= 1'b1;
            end
            CFG_IDLE: begin
               if (cfg_valid) begin
                  sh_int    <= cfg_int;
                  sh_frac   <= cfg_frac;
                  state     <= CFG_LOAD;
                  cfg_ready <= 1'b0;
               end
            end
            CFG_LOAD: begin
               act_int   <= sh_int;
               act_frac  <= sh_frac;
               state     <= CFG_IDLE;
               cfg_ready <= 1'b1;
            end
            default: begin
               state     <= CFG_INIT;
               cfg_ready <= 1'b0;
            end
         endcase
      end
   end

`ifdef FRAC_DSM_DITHER_EN
   logic [LFSR_W-1:0] lfsr;

   // Dither source, advances only while the modulator runs
   always_ff @(posedge refclk) begin
      if (!resetn) begin
         lfsr <= LFSR_SEED;
      end else if (enable) begin
         lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
      end
   end

   assign dith = lfsr[0];
`else
   assign dith = 1'b0;
`endif

   mash_stage #(.W(FRAC_W)) u_stage1 (
      .refclk  (refclk),
      .resetn  (resetn),
      .hold    (!enable),
      .din     (act_frac),
      .cin     (dith),
      .sum_c   (s1_sum_c),
      .carry_c (c1_c)
   );

   mash_stage #(.W(FRAC_W)) u_stage2 (
      .refclk  (refclk),
      .resetn  (resetn),
      .hold    (!enable),
      .din     (s1_sum_c),
      .cin     (1'b0),
      .sum_c   (s2_sum_c),
      .carry_c (c2_c)
   );

   mash_stage #(.W(FRAC_W)) u_stage3 (
      .refclk  (refclk),
      .resetn  (resetn),
      .hold    (!enable),
      .din     (s2_sum_c),
      .cin     (1'b0),
      .sum_c   (s3_sum_c),
      .carry_c (c3_c)
   );

   // Carry delay line for the differentiators, held with the accumulators
   always_ff @(posedge refclk) begin
      if (!resetn) begin
         c2_d  <= 1'b0;
         c3_d  <= 1'b0;
         c3_dd <= 1'b0;
      end else if (enable) begin
         c2_d  <= c2_c;
         c3_d  <= c3_c;
         c3_dd <= c3_d;
      end
   end

   // Ratio before clamping, integer part only while disabled
   always_comb begin
      off_c = mash_off(c1_c, c2_c, c2_d, c3_c, c3_d, c3_dd);
      raw_c = signed'(32'(act_int));
      if (enable) begin
         raw_c = raw_c + 32'(off_c);
      end
   end

   // Clamp to the legal divider range and flag when it bites
   always_comb begin
      divn_nxt_c = raw_c;
      sat_nxt_c  = 1'b0;
      if (raw_c < DIVN_MIN) begin
         divn_nxt_c = DIVN_MIN;
         sat_nxt_c  = 1'b1;
      end else if (raw_c > DIVN_MAX) begin
         divn_nxt_c = DIVN_MAX;
         sat_nxt_c  = 1'b1;
      end
   end

   // Registered ratio and saturation pulse
   always_ff @(posedge refclk) begin
      if (!resetn) begin
         divn <= DIVN_RST;
         sat  <= 1'b0;
      end else begin
         divn <= divn_nxt_c;
         sat  <= sat_nxt_c;
      end
   end

   // Unused sum of the last stage only feeds its own accumulator
   logic unused_ok;
   assign unused_ok = ^s3_sum_c;

endmodule

// File: tb/tb_frac_divn_dsm.sv
// Directed bench for frac_divn_dsm: hand-computed vector table plus
// sequences for reset, enable hold, clamping and long-run average.
module tb_frac_divn_dsm;

   logic               refclk;
   logic               resetn;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [7:0]         cfg_int;
   logic [15:0]        cfg_frac;
   logic               enable;
   logic signed [31:0] divn;
   logic               sat;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int m_acc1, m_acc2, m_acc3, m_c2d, m_c3d, m_c3dd;
   int m_int, m_frac, m_sh_int, m_sh_frac;
   int m_divn, m_sat, m_rdy, m_pend, m_init;

   typedef struct {
      logic       valid;
      logic [7:0] ci;
      logic [15:0] cf;
      logic       en;
      int         divn;
      int         sat;
      int         rdy;
   } vec_t;

   localparam int NV = 27;
   vec_t vec [NV];

   frac_divn_dsm dut (
      .refclk    (refclk),
      .resetn    (resetn),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_int   (cfg_int),
      .cfg_frac  (cfg_frac),
      .enable    (enable),
      .divn      (divn),
      .sat       (sat)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Behavioural model evaluated with the inputs present at the edge
   task automatic model_step();
      int n1, n2, n3, c1, c2, c3, off, raw;
      if (!resetn) begin
         m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
         m_c2d = 0; m_c3d = 0; m_c3dd = 0;
         m_int = 40; m_frac = 0; m_sh_int = 0; m_sh_frac = 0;
         m_divn = 40; m_sat = 0; m_rdy = 0; m_pend = 0; m_init = 1;
      end else begin
         raw = m_int;
         if (enable) begin
            n1 = m_acc1 + m_frac;  c1 = (n1 >= 65536) ? 1 : 0; n1 = n1 % 65536;
            n2 = m_acc2 + n1;      c2 = (n2 >= 65536) ? 1 : 0; n2 = n2 % 65536;
            n3 = m_acc3 + n2;      c3 = (n3 >= 65536) ? 1 : 0; n3 = n3 % 65536;
            off = c1 + (c2 - m_c2d) + (c3 - 2 * m_c3d + m_c3dd);
            m_acc1 = n1; m_acc2 = n2; m_acc3 = n3;
            m_c3dd = m_c3d; m_c3d = c3; m_c2d = c2;
            raw = m_int + off;
         end
         if (raw < 4) begin
            m_divn = 4; m_sat = 1;
         end else if (raw > 255) begin
            m_divn = 255; m_sat = 1;
         end else begin
            m_divn = raw; m_sat = 0;
         end
         if (m_init == 1) begin
            m_init = 0; m_rdy = 1;
         end else if (m_pend == 1) begin
            m_int = m_sh_int; m_frac = m_sh_frac; m_pend = 0; m_rdy = 1;
         end else if (cfg_valid) begin
            m_sh_int = int'(cfg_int); m_sh_frac = int'(cfg_frac);
            m_pend = 1; m_rdy = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      model_step();
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_divn"},  divn,      m_divn);
      chk({tag, "_sat"},   sat,       m_sat);
      chk({tag, "_ready"}, cfg_ready, m_rdy);
   endtask

   initial begin
      int seq [4];
      int sum, viol, dsat, msat;

      // Hand-computed: frac 0x8000 from clean state repeats 0,+2,-1,+1
      vec[0]  = '{1'b0, 8'd0,   16'h0000, 1'b1, 40,  0, 1};
      vec[1]  = '{1'b1, 8'd40,  16'h8000, 1'b1, 40,  0, 0};
      vec[2]  = '{1'b0, 8'd0,   16'h0000, 1'b1, 40,  0, 1};
      vec[3]  = '{1'b0, 8'd0,   16'h0000, 1'b1, 40,  0, 1};
      vec[4]  = '{1'b0, 8'd0,   16'h0000, 1'b1, 42,  0, 1};
      vec[5]  = '{1'b0, 8'd0,   16'h0000, 1'b1, 39,  0, 1};
      vec[6]  = '{1'b0, 8'd0,   16'h0000, 1'b1, 41,  0, 1};
      vec[7]  = '{1'b0, 8'd0,   16'h0000, 1'b1, 40,  0, 1};
      vec[8]  = '{1'b0, 8'd0,   16'h0000, 1'b1, 42,  0, 1};
      vec[9]  = '{1'b0, 8'd0,   16'h0000, 1'b1, 39,  0, 1};
      vec[10] = '{1'b0, 8'd0,   16'h0000, 1'b1, 41,  0, 1};
      // cfg_valid held 4 cycles: accepted at rows 11 and 13
      vec[11] = '{1'b1, 8'd50,  16'h8000, 1'b1, 40,  0, 0};
      vec[12] = '{1'b1, 8'd50,  16'h8000, 1'b1, 42,  0, 1};
      vec[13] = '{1'b1, 8'd50,  16'h8000, 1'b1, 49,  0, 0};
      vec[14] = '{1'b1, 8'd50,  16'h8000, 1'b1, 51,  0, 1};
      vec[15] = '{1'b0, 8'd0,   16'h0000, 1'b1, 50,  0, 1};
      vec[16] = '{1'b0, 8'd0,   16'h0000, 1'b1, 52,  0, 1};
      // Disabled clamping low and high, then resume from held state
      vec[17] = '{1'b1, 8'd2,   16'h8000, 1'b1, 49,  0, 0};
      vec[18] = '{1'b0, 8'd0,   16'h0000, 1'b0, 50,  0, 1};
      vec[19] = '{1'b0, 8'd0,   16'h0000, 1'b0, 4,   1, 1};
      vec[20] = '{1'b1, 8'd255, 16'h8000, 1'b0, 4,   1, 0};
      vec[21] = '{1'b0, 8'd0,   16'h0000, 1'b0, 4,   1, 1};
      vec[22] = '{1'b0, 8'd0,   16'h0000, 1'b0, 255, 0, 1};
      vec[23] = '{1'b0, 8'd0,   16'h0000, 1'b1, 255, 1, 1};
      vec[24] = '{1'b0, 8'd0,   16'h0000, 1'b1, 255, 0, 1};
      vec[25] = '{1'b0, 8'd0,   16'h0000, 1'b1, 255, 1, 1};
      vec[26] = '{1'b0, 8'd0,   16'h0000, 1'b1, 254, 0, 1};

      resetn = 1'b0; cfg_valid = 1'b0; cfg_int = '0; cfg_frac = '0; enable = 1'b1;
      tick(); tick();
      chk("reset_divn",  divn,      40);
      chk("reset_sat",   sat,       0);
      chk("reset_ready", cfg_ready, 0);
      resetn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         cfg_valid = vec[i].valid; cfg_int = vec[i].ci;
         cfg_frac = vec[i].cf;     enable = vec[i].en;
         tick();
         chk($sformatf("vec%0d_divn", i),  divn,      vec[i].divn);
         chk($sformatf("vec%0d_sat", i),   sat,       vec[i].sat);
         chk($sformatf("vec%0d_ready", i), cfg_ready, vec[i].rdy);
      end
      cfg_valid = 1'b0; enable = 1'b1;

      // Run at 0x4000 then a one-cycle reset mid-run
      cfg_valid = 1'b1; cfg_int = 8'd40; cfg_frac = 16'h4000;
      tick(); chk_model("cfg4000");
      cfg_valid = 1'b0;
      for (int i = 0; i < 22; i++) begin
         tick(); chk_model("run4000");
      end
      resetn = 1'b0;
      tick();
      chk("midrst_divn",  divn,      40);
      chk("midrst_sat",   sat,       0);
      chk("midrst_ready", cfg_ready, 0);
      resetn = 1'b1;
      tick();
      chk("midrst_ready_rise", cfg_ready, 1);
      chk("midrst_divn2",      divn,      40);

      // Cleared accumulators reproduce the clean 0x8000 pattern
      cfg_valid = 1'b1; cfg_int = 8'd40; cfg_frac = 16'h8000;
      tick(); chk("postrst_accept", cfg_ready, 0);
      cfg_valid = 1'b0;
      tick(); chk("postrst_load", cfg_ready, 1);
      seq[0] = 40; seq[1] = 42; seq[2] = 39; seq[3] = 41;
      for (int i = 0; i < 4; i++) begin
         tick(); chk($sformatf("postrst_seq%0d", i), divn, seq[i]);
      end

      // Long-run average and range at 40 + 0.5
      sum = 0; viol = 0;
      for (int i = 0; i < 256; i++) begin
         tick(); chk_model("avg");
         sum += divn;
         if (divn < 37 || divn > 44) viol++;
      end
      chk("avg_range_viol", viol, 0);
      chk("avg_sum_window", (sum >= 10364 && sum <= 10372) ? 1 : 0, 1);

      // Enable dropped for 10 cycles, modulator resumes from held state
      cfg_valid = 1'b1; cfg_int = 8'd40; cfg_frac = 16'h4000;
      tick(); chk_model("en_cfg");
      cfg_valid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick(); chk_model("en_pre");
      end
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("dis_divn", divn, 40);
         chk("dis_sat",  sat,  0);
      end
      enable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(); chk_model("en_post");
      end

      // Low clamp at cfg_int = DIVN_MIN with a tiny fraction
      resetn = 1'b0; tick(); resetn = 1'b1; tick();
      cfg_valid = 1'b1; cfg_int = 8'd4; cfg_frac = 16'h0001;
      tick(); cfg_valid = 1'b0;
      viol = 0; dsat = 0; msat = 0;
      for (int i = 0; i < 500; i++) begin
         tick();
         if (divn < 4) viol++;
         chk("clamp_sat", sat, m_sat);
         dsat += int'(sat);
         msat += m_sat;
      end
      chk("clamp_below_min", viol, 0);
      chk("clamp_sat_count", dsat, msat);
      chk("clamp_sat_seen",  (dsat > 0) ? 1 : 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
